// File: rtl/delay_line_taps_if.sv
// Sample/tap bus between the sample source (master) and the delay-line tap
// reader (slave).
interface delay_line_taps_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic [31:0]       delay_time;
  logic              out_valid;
  logic [DATA_W-1:0] tap_n;
  logic [DATA_W-1:0] tap_n_1;
  logic [DATA_W-1:0] tap_n_2;
  logic              overrun;

  modport master (
    output sample_valid, sample_in, delay_time,
    input  out_valid, tap_n, tap_n_1, tap_n_2, overrun
  );

  modport slave (
    input  sample_valid, sample_in, delay_time,
    output out_valid, tap_n, tap_n_1, tap_n_2, overrun
  );
endinterface

// File: rtl/delay_line_taps.sv
// Circular sample-history RAM that returns x(n), x(n-D) and x(n-2D) per
// accepted sample, masking taps that reach back past the samples written so far.
module delay_line_taps #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  delay_line_taps_if.slave bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [31:0]       MAX_D    = 32'((1 << (ADDR_W - 1)) - 1);
  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wp_q;
  logic [ADDR_W:0]   fill_q;
  logic [ADDR_W-2:0] deff_q;
  logic [ADDR_W-2:0] deff_d;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] tap1_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] a1_s;
  logic [ADDR_W-1:0] a2_s;
  logic [ADDR_W:0]   d1_s;
  logic [ADDR_W:0]   d2_s;
  logic              out_valid_q;
  logic [DATA_W-1:0] tap_n_q;
  logic [DATA_W-1:0] tap_n_1_q;
  logic [DATA_W-1:0] tap_n_2_q;
  logic              overrun_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Effective delay: zero maps to one, oversized values clamp to MAX_D.
  always_comb begin
    if (bus.delay_time == 32'd0) begin
      deff_d = {{(ADDR_W - 2){1'b0}}, 1'b1};
    end else if (bus.delay_time > MAX_D) begin
      deff_d = MAX_D[ADDR_W-2:0];
    end else begin
      deff_d = bus.delay_time[ADDR_W-2:0];
    end
  end

  assign a1_s = wp_q - {1'b0, deff_q};
  assign a2_s = wp_q - {deff_q, 1'b0};
  assign d1_s = {2'b00, deff_q};
  assign d2_s = {1'b0, deff_q, 1'b0};

  // Single RAM port address select.
  always_comb begin
    case (state_q)
      RD1:     addr_d = a1_s;
      RD2:     addr_d = a2_s;
      WR:      addr_d = wp_q;
      default: addr_d = wp_q;
    endcase
  end

  // RAM: contents survive reset so stale data must be masked by fill.
  always_ff @(posedge clk) begin
    if (!reset && state_q == WR) begin
      mem_q[wp_q] <= sample_q;
    end
    rd_data_q <= mem_q[addr_d];
  end

  // Sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wp_q        <= {ADDR_W{1'b0}};
      fill_q      <= {(ADDR_W + 1){1'b0}};
      deff_q      <= {(ADDR_W - 1){1'b0}};
      sample_q    <= {DATA_W{1'b0}};
      tap1_q      <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      tap_n_q     <= {DATA_W{1'b0}};
      tap_n_1_q   <= {DATA_W{1'b0}};
      tap_n_2_q   <= {DATA_W{1'b0}};
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            sample_q <= bus.sample_in;
            deff_q   <= deff_d;
            state_q  <= RD1;
          end
        end
        RD1: state_q <= RD2;
        RD2: begin
          tap1_q  <= (fill_q < d1_s) ? {DATA_W{1'b0}} : rd_data_q;
          state_q <= WR;
        end
        WR: begin
          out_valid_q <= 1'b1;
          tap_n_q     <= sample_q;
          tap_n_1_q   <= tap1_q;
          tap_n_2_q   <= (fill_q < d2_s) ? {DATA_W{1'b0}} : rd_data_q;
          wp_q        <= wp_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + {{ADDR_W{1'b0}}, 1'b1};
          end
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE && bus.sample_valid) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.tap_n     = tap_n_q;
  assign bus.tap_n_1   = tap_n_1_q;
  assign bus.tap_n_2   = tap_n_2_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_delay_line_taps.sv
// Scoreboard bench for delay_line_taps: a sample-history model predicts each
// output triple, and a negedge monitor compares every out_valid pulse.
module tb_delay_line_taps;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int MAXD   = (1 << (ADDR_W - 1)) - 1;

  typedef struct {
    logic [15:0] t0;
    logic [15:0] t1;
    logic [15:0] t2;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  delay_line_taps_if #(.DATA_W(DATA_W)) bus ();

  delay_line_taps #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          since = 100;
  int          n_pulse = 0;
  bit          mon_en = 1'b0;
  bit          exp_ovr = 1'b0;
  logic [15:0] hist[$];
  exp_t        sb[$];
  exp_t        last;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock: present inputs, let the edge happen, then update the model.
  task automatic drive(input bit v, input logic [15:0] d, input logic [31:0] dt);
    exp_t e;
    int   deff;
    int   k;
    bus.sample_valid = v;
    bus.sample_in    = d;
    bus.delay_time   = dt;
    @(posedge clk);
    cyc++;
    since++;
    if (v) begin
      if (since >= 4) begin
        since = 0;
        deff  = (dt == 32'd0) ? 1 : ((dt > 32'(MAXD)) ? MAXD : int'(dt));
        k     = hist.size();
        e.t0  = d;
        e.t1  = (k >= deff) ? hist[k - deff] : 16'h0000;
        e.t2  = (k >= 2 * deff) ? hist[k - 2 * deff] : 16'h0000;
        e.cyc = cyc + 3;
        hist.push_back(d);
        sb.push_back(e);
      end else begin
        exp_ovr = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 32'd0);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    @(posedge clk);
    cyc++;
    hist.delete();
    sb.delete();
    since   = 100;
    exp_ovr = 1'b0;
    last.t0 = 16'h0000;
    last.t1 = 16'h0000;
    last.t2 = 16'h0000;
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: pop on every out_valid, otherwise outputs must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("overrun", {31'd0, bus.overrun}, {31'd0, exp_ovr});
      if (bus.out_valid) begin
        n_pulse++;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", 32'(cyc), 32'(mon_e.cyc));
          last = mon_e;
        end
      end
      chk("tap_n", {16'd0, bus.tap_n}, {16'd0, last.t0});
      chk("tap_n_1", {16'd0, bus.tap_n_1}, {16'd0, last.t1});
      chk("tap_n_2", {16'd0, bus.tap_n_2}, {16'd0, last.t2});
    end
  end

  initial begin
    int p0;
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = 16'h0000;
    bus.delay_time   = 32'd0;
    do_reset();
    idle(2);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_tap_n", {16'd0, bus.tap_n}, 32'd0);

    // First sample after reset: both taps masked.
    drive(1'b1, 16'h1234, 32'd2);
    idle(5);
    chk("first_tap_n", {16'd0, bus.tap_n}, 32'h1234);

    // Ramp with D=2.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 32'd2);
      idle(3);
    end
    idle(2);
    chk("d2_tap_n", {16'd0, bus.tap_n}, 32'd5);
    chk("d2_tap_n_1", {16'd0, bus.tap_n_1}, 32'd3);
    chk("d2_tap_n_2", {16'd0, bus.tap_n_2}, 32'd1);

    // Clamped delay with pointer wrap.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 16'(i), 32'd100);
      idle(3);
    end
    idle(2);
    chk("wrap_tap_n", {16'd0, bus.tap_n}, 32'd40);
    chk("wrap_tap_n_1", {16'd0, bus.tap_n_1}, 32'd33);
    chk("wrap_tap_n_2", {16'd0, bus.tap_n_2}, 32'd26);

    // Zero delay behaves as one.
    do_reset();
    for (int i = 7; i <= 9; i++) begin
      drive(1'b1, 16'(i), 32'd0);
      idle(3);
    end
    idle(2);
    chk("d0_tap_n", {16'd0, bus.tap_n}, 32'd9);
    chk("d0_tap_n_1", {16'd0, bus.tap_n_1}, 32'd8);
    chk("d0_tap_n_2", {16'd0, bus.tap_n_2}, 32'd7);

    // sample_valid held for 8 cycles.
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'h0100 + i), 32'd1);
    idle(10);
    chk("burst_pulses", 32'(n_pulse - p0), 32'd2);
    chk("burst_overrun", {31'd0, bus.overrun}, 32'd1);

    // Reset mid-operation aborts, then stale RAM must stay masked.
    drive(1'b1, 16'hBEEF, 32'd1);
    drive(1'b0, 16'h0000, 32'd1);
    p0 = n_pulse;
    do_reset();
    idle(6);
    chk("abort_pulses", 32'(n_pulse - p0), 32'd0);
    chk("abort_tap_n", {16'd0, bus.tap_n}, 32'd0);
    drive(1'b1, 16'h0042, 32'd1);
    idle(5);
    chk("post_abort_tap_n_1", {16'd0, bus.tap_n_1}, 32'd0);
    chk("post_abort_tap_n_2", {16'd0, bus.tap_n_2}, 32'd0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 2) == 0, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20)));
      end
    end
    idle(8);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
